// File: rtl/incr_sched_pkg.sv
// incr_sched shared types: sequencer state and default sizing.
// Optional perf counter build: define INCR_SCHED_PERF_EN.
package incr_pkg;

  localparam int NUM_REQ_D = 4;
  localparam int DATA_W_D  = 4;
  localparam int PERF_W    = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/incr_sched_if.sv
// Request/response bundle between clients and the shared incrementer.
// master = client side, slave = incr_sched side.
interface incr_sched_if
  import incr_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int DATA_W  = DATA_W_D
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      rsp_valid_o;
  logic                      rsp_ready_i;
  logic [ID_W-1:0]           rsp_id_o;
  logic [DATA_W-1:0]         rsp_data_o;

  modport master (
    output req_valid_i, req_data_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

  modport slave (
    input  req_valid_i, req_data_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o
  );

endinterface

// File: rtl/incr_rr_arb.sv
// Combinational round-robin arbiter: searches from ptr+1 upward
// with wrap, returns one-hot grant and encoded winner.
module incr_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  int              c;
  logic [ID_W-1:0] ci;
  logic            found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c  = (int'(ptr) + i) % NUM_REQ;
      ci = ID_W'(c);
      if (!found && req[ci]) begin
        found   = 1'b1;
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/incr_sched.sv
// Round-robin shared 4-bit incrementer: IDLE grant, EXEC, RESP.
// Define INCR_SCHED_PERF_EN to add the response-handshake counter.
module incr_sched
  import incr_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_D,
  parameter int DATA_W  = DATA_W_D,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  incr_sched_if.slave  bus,
  output logic         busy_o
`ifdef INCR_SCHED_PERF_EN
  ,
  input  logic              perf_clr_i,
  output logic [PERF_W-1:0] perf_cnt_o
`endif
);

  state_e state_q, state_d;

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [DATA_W-1:0]  op_q;
  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_data_q;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    win;
  logic               any_req;
  logic               accept;
  logic               load_rsp;
  logic               rsp_hs;

  assign any_req = |bus.req_valid_i;

  incr_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (bus.req_valid_i),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = '0;
    busy_o          = 1'b1;
    accept          = 1'b0;
    load_rsp        = 1'b0;
    rsp_hs          = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready_o = gnt;
        busy_o          = 1'b0;
        accept          = any_req;
      end
      EXEC:    load_rsp = 1'b1;
      RESP:    rsp_hs   = bus.rsp_ready_i;
      default: busy_o   = 1'b1;
    endcase
  end

  // Result id/data only move in EXEC so they hold while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_data_i[win*DATA_W +: DATA_W];
        id_q  <= win;
        ptr_q <= win;
      end
      if (load_rsp) begin
        rsp_data_q  <= op_q + DATA_W'(1);
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end else if (rsp_hs) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_id_o    = rsp_id_q;
  assign bus.rsp_data_o  = rsp_data_q;

`ifdef INCR_SCHED_PERF_EN
  logic [PERF_W-1:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                    perf_q <= '0;
    else if (perf_clr_i)            perf_q <= '0;
    else if (rsp_hs && perf_q != '1) perf_q <= perf_q + PERF_W'(1);
  end

  assign perf_cnt_o = perf_q;
`endif

endmodule

// File: doc/incr_sched.md
Name: incr_sched

Overview:
- Shares one registered 4-bit incrementer datapath between NUM_REQ requesters.
- Round-robin arbiter plus a 3-state sequencer: grant, execute, respond.
- Sits between multiple client blocks and the increment resource.
- Returns data+1 tagged with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 4, operand/result width
- ID_W, $clog2(NUM_REQ), requester ID width (derived; not overridden)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_data_i  in  NUM_REQ*DATA_W  per-requester operand; slice k = bits [k*DATA_W +: DATA_W]
- req_ready_o  out  NUM_REQ  one-hot grant/accept, combinational
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer ready
- rsp_id_o  out  ID_W  index of the requester that issued the result
- rsp_data_o  out  DATA_W  operand + 1, modulo 2^DATA_W
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values: state=IDLE, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, busy_o=0, rr pointer=NUM_REQ-1 (requester 0 wins first).
- req_ready_o:
  - 0 outside IDLE.
  - In IDLE, it is the one-hot round-robin winner among req_valid_i, searching from pointer+1 upward with wrap.
  - 0 if no request is valid.
- IDLE: on any req_valid_i, the winner handshake completes in that cycle. Capture operand and ID, set pointer=winner, go to EXEC.
- EXEC: one cycle. Register captured operand + 1, truncated to DATA_W, into rsp_data_o. Set rsp_valid_o=1 and go to RESP.
  - Wrap rule: all-ones gives 0; there is no carry out.
- RESP: hold rsp_valid_o, rsp_id_o and rsp_data_o stable until rsp_ready_i=1.
  - On the handshake cycle, rsp_valid_o goes to 0 on the next edge and state returns to IDLE.
  - rsp_ready_i is ignored outside RESP.
- Latency and throughput:
  - Request accept to rsp_valid_o is 2 cycles.
  - Back-to-back grants occur at most once per 3 cycles (IDLE-EXEC-RESP) when rsp_ready_i is held 1.
- Requesters deasserting valid before grant: allowed; they are simply not granted.
- req_data_i is only sampled on the accept cycle.
- Pointer updates only on grant. A single persistent requester is re-granted every round.
- Reset mid-operation: any in-flight request is discarded, outputs return to reset values immediately (async), and no response is issued after reset.
- No X propagation: rsp_data_o and rsp_id_o retain their last values when rsp_valid_o=0.

Optional Feature:
- Macro: INCR_SCHED_PERF_EN.
- When defined:
  - Adds output perf_cnt_o [15:0], the count of completed response handshakes.
  - Saturates at 16'hFFFF and resets to 0.
  - Adds input perf_clr_i [1]: synchronous clear, which takes priority over increment in the same cycle.
- When undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package incr_pkg holds:
  - state enum {IDLE, EXEC, RESP}, 2-bit encoding
  - default NUM_REQ/DATA_W localparams
  - PERF_W=16
- Sub-module incr_rr_arb:
  - purely combinational
  - inputs: req vector and pointer
  - outputs: one-hot grant and encoded winner index
- incr_sched instantiates it and owns the pointer register.

Test Plan:
- Reset, then req_valid_i=4'b0001, req_data_i slice0=4'h3, rsp_ready_i=1 -> req_ready_o=0001 in the same cycle; 2 cycles later rsp_valid_o=1, rsp_id_o=0, rsp_data_o=4'h4.
- All four valid, data={F,2,7,A}, rsp_ready_i=1 -> grants in order 0,1,2,3,0; results A->B (id0), 7->8 (id1), 2->3 (id2), F->0 (id3, wrap).
- Response backpressure: rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o/rsp_id_o/rsp_data_o stable, req_ready_o=0, busy_o=1; then ready=1 -> return to IDLE next edge.
- Async reset asserted during EXEC with operand 4'h5 -> outputs 0 immediately; after release, no stale response; next grant goes to requester 0.
- Requester 2 holds valid continuously alone -> granted every 3 cycles; then req 1 joins -> next grant to req 1 only if it follows the pointer order after 2 (expect 1 after 2 wraps: sequence 2,1,2,1).
- With INCR_SCHED_PERF_EN: 3 completed responses -> perf_cnt_o=3; perf_clr_i coincident with a handshake -> perf_cnt_o=0.
